// File: rtl/snn_l1_engine_if.sv
// Pattern-input / result bus of the spiking-feature distance engine.
//   in_valid, img, ker, weight, mode : frame stream from the pattern source
//   busy, out_valid, out_data        : engine status and distance result
// master = stream source / result sink, slave = engine.
interface snn_l1_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 10
) ();
  logic              in_valid;
  logic [DATA_W-1:0] img;
  logic [DATA_W-1:0] ker;
  logic [DATA_W-1:0] weight;
  logic              mode;
  logic              busy;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output in_valid, img, ker, weight, mode,
    input  busy, out_valid, out_data
  );

  modport slave (
    input  in_valid, img, ker, weight, mode,
    output busy, out_valid, out_data
  );
endinterface

// File: rtl/snn_l1_engine.sv
// Two-image spiking-feature comparator: per image 3x3 convolution, quantisation,
// 2x2 max-pool, PxP fully-connected stage and second quantisation; reports the
// thresholded L1 (mode 0) or L-infinity (mode 1) distance of the feature vectors.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : snn_l1_engine_if.slave (in_valid/img/ker/weight/mode in,
//                busy/out_valid/out_data out)
module snn_l1_engine #(
  parameter int unsigned IMG_W    = 6,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CONV_DIV = 2295,
  parameter int unsigned FC_DIV   = 510,
  parameter int unsigned THRESH   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  snn_l1_engine_if.slave bus
);

  localparam int unsigned FM     = IMG_W - 2;
  localparam int unsigned P      = FM / 2;
  localparam int unsigned PP     = P * P;
  localparam int unsigned NPIX   = IMG_W * IMG_W;
  localparam int unsigned OUT_W  = DATA_W + $clog2(PP);
  localparam int unsigned CNT_W  = $clog2(2 * NPIX);
  localparam int unsigned FMI_W  = $clog2(FM * FM);
  localparam int unsigned WI_W   = $clog2(PP);
  localparam int unsigned FQI_W  = $clog2(2 * PP);
  localparam int unsigned RC_W   = $clog2(FM);
  localparam int unsigned PI_W   = $clog2(P);
  localparam int unsigned CSUM_W = 2 * DATA_W + 4;
  localparam int unsigned FSUM_W = 2 * DATA_W + $clog2(P) + 1;
  localparam logic [DATA_W-1:0] QMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_POOL_FC,
    S_DIST,
    S_OUT
  } state_t;

  state_t state_q, state_nx;

  // frame storage
  logic [DATA_W-1:0] img_mem [2*NPIX];
  logic [DATA_W-1:0] ker_mem [9];
  logic [DATA_W-1:0] w_mem   [PP];
  logic [DATA_W-1:0] fmap    [FM*FM];
  logic [DATA_W-1:0] fq_mem  [2*PP];
  logic              mode_q;

  // load / compute bookkeeping
  logic [CNT_W-1:0] ld_cnt_q;
  logic             loading_q;
  logic             ld_done_q;
  logic [RC_W-1:0]  conv_r_q, conv_c_q;
  logic [PI_W-1:0]  fc_i_q, fc_j_q;
  logic             img_sel_q;

  logic              busy_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;

  logic              cap_c;
  logic              img1_ready_c;
  logic              conv_last_c, fc_last_c;
  logic              conv_step_c, fc_step_c;

  logic [CSUM_W-1:0] conv_sum, conv_quot;
  logic [DATA_W-1:0] conv_q_c;
  int                img_base;

  logic [FSUM_W-1:0] fc_sum, fc_quot;
  logic [DATA_W-1:0] pool_m, pix;
  logic [DATA_W-1:0] fc_q_c;

  logic [DATA_W-1:0] fq_a, fq_b, dn, dist_max;
  logic [OUT_W-1:0]  dist_sum, dist_r, dist_res_c;

  // Data is accepted on the first in_valid seen in IDLE and then only while the
  // frame is still streaming; stray in_valid at any other time is dropped.
  assign cap_c        = bus.in_valid && ((state_q == S_IDLE) || loading_q);
  assign img1_ready_c = ld_done_q || (ld_cnt_q >= CNT_W'(NPIX));
  assign conv_last_c  = (conv_r_q == RC_W'(FM - 1)) && (conv_c_q == RC_W'(FM - 1));
  assign fc_last_c    = (fc_i_q == PI_W'(P - 1)) && (fc_j_q == PI_W'(P - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nx;
  end

  // Next state and per-cycle compute strobes; image 2 convolution waits for the
  // last pixel of image 2, image 1 work overlaps the image 2 stream.
  always_comb begin
    state_nx    = state_q;
    conv_step_c = 1'b0;
    fc_step_c   = 1'b0;
    case (state_q)
      S_IDLE:    if (bus.in_valid) state_nx = S_LOAD;
      S_LOAD:    if (img1_ready_c) state_nx = S_CONV;
      S_CONV: begin
        if (!img_sel_q || ld_done_q) begin
          conv_step_c = 1'b1;
          if (conv_last_c) state_nx = S_POOL_FC;
        end
      end
      S_POOL_FC: begin
        fc_step_c = 1'b1;
        if (fc_last_c) state_nx = img_sel_q ? S_DIST : S_CONV;
      end
      S_DIST:    state_nx = S_OUT;
      S_OUT:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Frame capture: pixels of both images, kernel, weights and mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q  <= '0;
      loading_q <= 1'b0;
      ld_done_q <= 1'b0;
      mode_q    <= 1'b0;
      for (int i = 0; i < int'(2 * NPIX); i++) img_mem[CNT_W'(i)] <= '0;
      for (int i = 0; i < 9; i++)              ker_mem[4'(i)]     <= '0;
      for (int i = 0; i < int'(PP); i++)       w_mem[WI_W'(i)]    <= '0;
    end else begin
      if (cap_c) begin
        img_mem[ld_cnt_q] <= bus.img;
        if (ld_cnt_q < CNT_W'(9))  ker_mem[4'(ld_cnt_q)]  <= bus.ker;
        if (ld_cnt_q < CNT_W'(PP)) w_mem[WI_W'(ld_cnt_q)] <= bus.weight;
        if (ld_cnt_q == '0)        mode_q                 <= bus.mode;
        if (ld_cnt_q == CNT_W'(2 * NPIX - 1)) begin
          ld_cnt_q  <= '0;
          loading_q <= 1'b0;
          ld_done_q <= 1'b1;
        end else begin
          ld_cnt_q  <= ld_cnt_q + 1'b1;
          loading_q <= 1'b1;
        end
      end else if (state_q == S_OUT) begin
        ld_done_q <= 1'b0;
      end
    end
  end

  // One convolution output per cycle, quantised with exact floor division
  always_comb begin
    conv_sum = '0;
    img_base = img_sel_q ? int'(NPIX) : 0;
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) begin
        conv_sum = conv_sum
                 + CSUM_W'(img_mem[CNT_W'(img_base + (int'(conv_r_q) + a) * int'(IMG_W)
                                          + int'(conv_c_q) + b)])
                 * CSUM_W'(ker_mem[4'(a * 3 + b)]);
      end
    end
    conv_quot = conv_sum / CSUM_W'(CONV_DIV);
    conv_q_c  = (conv_quot > CSUM_W'(QMAX)) ? QMAX : DATA_W'(conv_quot);
  end

  // One FC output F[i][j] per cycle; the pooled row M[i][*] is formed on the fly
  always_comb begin
    fc_sum = '0;
    pool_m = '0;
    pix    = '0;
    for (int k = 0; k < int'(P); k++) begin
      pool_m = '0;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          pix = fmap[FMI_W'((2 * int'(fc_i_q) + dr) * int'(FM) + 2 * k + dc)];
          if (pix > pool_m) pool_m = pix;
        end
      end
      fc_sum = fc_sum + FSUM_W'(pool_m)
                      * FSUM_W'(w_mem[WI_W'(k * int'(P) + int'(fc_j_q))]);
    end
    fc_quot = fc_sum / FSUM_W'(FC_DIV);
    fc_q_c  = (fc_quot > FSUM_W'(QMAX)) ? QMAX : DATA_W'(fc_quot);
  end

  // Convolution / FC sequencing and result storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_r_q  <= '0;
      conv_c_q  <= '0;
      fc_i_q    <= '0;
      fc_j_q    <= '0;
      img_sel_q <= 1'b0;
      for (int i = 0; i < int'(FM * FM); i++) fmap[FMI_W'(i)]   <= '0;
      for (int i = 0; i < int'(2 * PP); i++)  fq_mem[FQI_W'(i)] <= '0;
    end else begin
      if (conv_step_c) begin
        fmap[FMI_W'(int'(conv_r_q) * int'(FM) + int'(conv_c_q))] <= conv_q_c;
        if (conv_c_q == RC_W'(FM - 1)) begin
          conv_c_q <= '0;
          conv_r_q <= (conv_r_q == RC_W'(FM - 1)) ? '0 : conv_r_q + 1'b1;
        end else begin
          conv_c_q <= conv_c_q + 1'b1;
        end
      end
      if (fc_step_c) begin
        fq_mem[FQI_W'(int'(img_sel_q) * int'(PP) + int'(fc_i_q) * int'(P) + int'(fc_j_q))] <= fc_q_c;
        if (fc_j_q == PI_W'(P - 1)) begin
          fc_j_q <= '0;
          fc_i_q <= (fc_i_q == PI_W'(P - 1)) ? '0 : fc_i_q + 1'b1;
        end else begin
          fc_j_q <= fc_j_q + 1'b1;
        end
        if (fc_last_c) img_sel_q <= ~img_sel_q;
      end
    end
  end

  // Distance between the two quantised feature vectors, then thresholding
  always_comb begin
    dist_sum = '0;
    dist_max = '0;
    fq_a     = '0;
    fq_b     = '0;
    dn       = '0;
    for (int n = 0; n < int'(PP); n++) begin
      fq_a     = fq_mem[FQI_W'(n)];
      fq_b     = fq_mem[FQI_W'(int'(PP) + n)];
      dn       = (fq_a >= fq_b) ? (fq_a - fq_b) : (fq_b - fq_a);
      dist_sum = dist_sum + OUT_W'(dn);
      if (dn > dist_max) dist_max = dn;
    end
    dist_r     = mode_q ? OUT_W'(dist_max) : dist_sum;
    dist_res_c = (dist_r < OUT_W'(THRESH)) ? '0 : dist_r;
  end

  // Registered outputs: result strobe during OUT, busy from frame start to OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= (state_q == S_DIST);
      out_data_q  <= (state_q == S_DIST) ? dist_res_c : '0;
      if ((state_q == S_IDLE) && bus.in_valid) busy_q <= 1'b1;
      else if (state_q == S_OUT)                busy_q <= 1'b0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_snn_l1_engine.sv
// Bench for snn_l1_engine: a default 6x6 instance (directed, reset-abort,
// back-to-back and stray-in_valid frames) and a 10x10 instance (random frames),
// both checked against a plain-arithmetic reference of the feature pipeline.
module tb_snn_l1_engine;

  localparam int unsigned DW     = 8;
  localparam int unsigned OW6    = DW + $clog2(((6 - 2) / 2) * ((6 - 2) / 2));
  localparam int unsigned OW10   = DW + $clog2(((10 - 2) / 2) * ((10 - 2) / 2));
  localparam int          CDIV   = 2295;
  localparam int          THR    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_l1_engine_if #(.DATA_W(DW), .OUT_W(OW6))  bus6  ();
  snn_l1_engine_if #(.DATA_W(DW), .OUT_W(OW10)) bus10 ();

  snn_l1_engine #(.IMG_W(6), .DATA_W(DW), .CONV_DIV(2295), .FC_DIV(510), .THRESH(16))
    dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  snn_l1_engine #(.IMG_W(10), .DATA_W(DW), .CONV_DIV(2295), .FC_DIV(1020), .THRESH(16))
    dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));

  int n_cmp = 0;
  int n_err = 0;

  int img_a [800];
  int ker_a [9];
  int w_a   [16];
  bit mode_v;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rb();
    return int'($urandom_range(0, 255));
  endfunction

  function automatic int get_ov(input int which);
    return (which != 0) ? int'(bus10.out_valid) : int'(bus6.out_valid);
  endfunction

  function automatic int get_busy(input int which);
    return (which != 0) ? int'(bus10.busy) : int'(bus6.busy);
  endfunction

  function automatic int get_od(input int which);
    return (which != 0) ? int'(bus10.out_data) : int'(bus6.out_data);
  endfunction

  task automatic drive(input int which, input bit v, input int im, input int k,
                       input int wt, input bit md);
    if (which == 0) begin
      bus6.in_valid = v;  bus6.img = DW'(im);  bus6.ker = DW'(k);
      bus6.weight = DW'(wt);  bus6.mode = md;
    end else begin
      bus10.in_valid = v; bus10.img = DW'(im); bus10.ker = DW'(k);
      bus10.weight = DW'(wt); bus10.mode = md;
    end
  endtask

  // Reference: straight from the definition of each stage
  function automatic int golden(input int w, input int fdiv);
    int fm, p, s, q, mx, f, d, dsum, dmax, r;
    int fmap [8][8];
    int mp   [4][4];
    int fq   [2][16];
    fm = w - 2;
    p  = fm / 2;
    for (int im = 0; im < 2; im++) begin
      for (int rr = 0; rr < fm; rr++)
        for (int cc = 0; cc < fm; cc++) begin
          s = 0;
          for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
              s += img_a[im * w * w + (rr + a) * w + cc + b] * ker_a[a * 3 + b];
          q = s / CDIV;
          fmap[rr][cc] = (q > 255) ? 255 : q;
        end
      for (int i = 0; i < p; i++)
        for (int k = 0; k < p; k++) begin
          mx = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (fmap[2 * i + dr][2 * k + dc] > mx) mx = fmap[2 * i + dr][2 * k + dc];
          mp[i][k] = mx;
        end
      for (int i = 0; i < p; i++)
        for (int j = 0; j < p; j++) begin
          f = 0;
          for (int k = 0; k < p; k++) f += mp[i][k] * w_a[k * p + j];
          q = f / fdiv;
          fq[im][i * p + j] = (q > 255) ? 255 : q;
        end
    end
    dsum = 0;
    dmax = 0;
    for (int n = 0; n < p * p; n++) begin
      d = fq[0][n] - fq[1][n];
      if (d < 0) d = -d;
      dsum += d;
      if (d > dmax) dmax = d;
    end
    r = mode_v ? dmax : dsum;
    return (r < THR) ? 0 : r;
  endfunction

  task automatic fill_const(input int w, input int v1, input int v2, input int kv,
                            input int wv, input bit md);
    for (int i = 0; i < w * w; i++) begin
      img_a[i]         = v1;
      img_a[w * w + i] = v2;
    end
    for (int i = 0; i < 9; i++)  ker_a[i] = kv;
    for (int i = 0; i < 16; i++) w_a[i]   = wv;
    mode_v = md;
  endtask

  task automatic fill_rand(input int w);
    for (int i = 0; i < 2 * w * w; i++) img_a[i] = rb();
    for (int i = 0; i < 9; i++)  ker_a[i] = rb();
    for (int i = 0; i < 16; i++) w_a[i]   = rb();
    mode_v = 1'($urandom_range(0, 1));
  endtask

  // Starts at a falling edge; returns at the falling edge of the cycle after
  // out_valid so the next frame can start there back-to-back.
  task automatic run_frame(input int which, input string tag, input int expv, input bit inject);
    int  w, n, p, bound, spur, j;
    bit  seen;
    w     = (which != 0) ? 10 : 6;
    n     = w * w;
    p     = (w - 2) / 2;
    bound = (w - 2) * (w - 2) + p * p + 16;
    spur  = 0;
    for (int c = 0; c < 2 * n; c++) begin
      if (c == 1) check_val({tag, "/busy_in_frame"}, get_busy(which), 1);
      if (get_ov(which) != 0) spur++;
      drive(which, 1'b1, img_a[c],
            (c < 9) ? ker_a[c] : rb(),
            (c < p * p) ? w_a[c] : rb(),
            (c == 0) ? mode_v : 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    drive(which, 1'b0, rb(), rb(), rb(), 1'b0);
    seen = 1'b0;
    j    = 1;
    while (!seen && j <= bound + 8) begin
      if (get_ov(which) != 0) begin
        seen = 1'b1;
      end else begin
        if (inject && j >= 2 && j <= 4) drive(which, 1'b1, rb(), rb(), rb(), 1'b1);
        else                            drive(which, 1'b0, rb(), rb(), rb(), 1'b0);
        @(negedge clk);
        j++;
      end
    end
    check_val({tag, "/out_valid_seen"}, int'(seen), 1);
    check_val({tag, "/latency_ok"}, (seen && j <= bound) ? 1 : 0, 1);
    check_val({tag, "/out_data"}, get_od(which), expv);
    check_val({tag, "/early_pulses"}, spur, 0);
    @(negedge clk);
    check_val({tag, "/out_valid_drop"}, get_ov(which), 0);
    check_val({tag, "/busy_drop"}, get_busy(which), 0);
    check_val({tag, "/out_data_zero"}, get_od(which), 0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int spur;
    int expv;
    drive(0, 1'b0, 0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst/busy6", get_busy(0), 0);
    check_val("rst/ov6", get_ov(0), 0);
    check_val("rst/od6", get_od(0), 0);
    check_val("rst/busy10", get_busy(1), 0);
    check_val("rst/ov10", get_ov(1), 0);
    check_val("rst/od10", get_od(1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // identical saturated images: zero distance
    fill_const(6, 255, 255, 255, 255, 1'b0);
    run_frame(0, "all255_l1", 0, 1'b0);

    // maximal difference, L1 then L-inf back-to-back with stray in_valid
    fill_const(6, 255, 0, 255, 255, 1'b0);
    run_frame(0, "maxdiff_l1", 1020, 1'b0);
    fill_const(6, 255, 0, 255, 255, 1'b1);
    run_frame(0, "maxdiff_linf", 255, 1'b1);

    // threshold edge: fq1=5 vs 2 -> 12 suppressed; fq1=6 vs 2 -> 16 reported
    fill_const(6, 5, 2, 255, 255, 1'b0);
    run_frame(0, "thresh_below", 0, 1'b0);
    fill_const(6, 6, 2, 255, 255, 1'b0);
    run_frame(0, "thresh_at", 16, 1'b0);

    // reset in the middle of frame A, then frame B alone
    fill_rand(6);
    for (int c = 0; c < 40; c++) begin
      drive(0, 1'b1, img_a[c], (c < 9) ? ker_a[c] : rb(), (c < 4) ? w_a[c] : rb(), mode_v);
      @(negedge clk);
    end
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0, 0, 1'b0);
    #1;
    check_val("abort/busy", get_busy(0), 0);
    check_val("abort/ov", get_ov(0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    repeat (50) begin
      @(negedge clk);
      if (get_ov(0) != 0) spur++;
    end
    check_val("abort/stale_pulse", spur, 0);
    fill_rand(6);
    run_frame(0, "abort_frameB", golden(6, 510), 1'b0);

    // back-to-back random frames with different mode and kernel
    fill_rand(6);
    mode_v = 1'b1;
    run_frame(0, "b2b_first", golden(6, 510), 1'b0);
    fill_rand(6);
    mode_v = 1'b0;
    run_frame(0, "b2b_second", golden(6, 510), 1'b0);

    // 10x10 instance, random frames
    for (int i = 0; i < 200; i++) begin
      fill_rand(10);
      expv = golden(10, 1020);
      run_frame(1, $sformatf("r10_%0d", i), expv, 1'b0);
      if ((i % 16) == 5) repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
